skein_host_seq: RTL and testbench

- Host-side sequencer for the skein_top core; drives its init/load/fetch handshake.
- A requester supplies one message block as a 16-bit word stream. The block issues init, loads each word with ack handshake, fetches the digest words and returns them on a valid/ready stream.
- Provides an ack timeout watchdog and abort, so the system can run the hash core without software bit-banging.

---
 rtl/skein_host_seq.sv | 186 ++++++++++++++++++
 tb/tb_skein_host_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skein_host_seq.sv
// skein_host_seq: host-side sequencer driving the skein_top init/load/fetch handshake.
// Define SKEIN_SEQ_CYCLE_COUNT_EN to add the cycles[31:0] hash-latency output.
module skein_host_seq #(
  parameter int W         = 16,
  parameter int MSG_WORDS = 32,
  parameter int DIG_WORDS = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         core_init,
  output logic         core_load,
  output logic         core_fetch,
  output logic [W-1:0] core_idata,
  input  logic         core_ack,
  input  logic [W-1:0] core_odata
`ifdef SKEIN_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]  cycles
`endif
);

  localparam int CW = $clog2(MSG_WORDS + 1);
  localparam int FW = $clog2(DIG_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_FETCH, S_OUT, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [FW-1:0]  fet_cnt_q, fet_cnt_d;
  logic [TW-1:0]  wd_q, wd_d;
  logic [W-1:0]   out_data_q, out_data_d;

  logic strobe, load_ack, fetch_ack, last_load, wd_expire, accept, out_hs, last_out;

  assign strobe    = core_load | core_fetch;
  assign load_ack  = core_load & core_ack;
  assign fetch_ack = core_fetch & core_ack;
  assign last_load = load_ack && (ld_cnt_q == CW'(MSG_WORDS - 1));
  assign wd_expire = strobe && !core_ack && (wd_q == TW'(TIMEOUT - 1));
  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_out  = out_hs && (fet_cnt_q == FW'(DIG_WORDS - 1));

  // NOTE: asynchronous reset must appear in the sensitivity list; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // abort outranks every transition, including ERR's hold.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_INIT;
        S_INIT:  state_d = S_LOAD;
        S_LOAD: begin
          if (wd_expire)      state_d = S_ERR;
          else if (last_load) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (wd_expire)     state_d = S_ERR;
          else if (core_ack) state_d = S_OUT;
        end
        S_OUT:   if (out_ready) state_d = last_out ? S_IDLE : S_FETCH;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    core_init  = (state_q == S_INIT);
    core_load  = (state_q == S_LOAD) && hold_full_q;
    core_fetch = (state_q == S_FETCH);
    core_idata = hold_full_q ? hold_q : '0;
    in_ready   = (state_q == S_LOAD) && (acc_cnt_q < CW'(MSG_WORDS))
                 && (!hold_full_q || core_ack);
    out_valid  = (state_q == S_OUT);
    out_data   = out_data_q;
    busy       = (state_q != S_IDLE);
    err        = (state_q == S_ERR);
    done       = last_out;
  end

  // NOTE: every _d takes its _q value first so no path leaves it unassigned (no latch).
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acc_cnt_d   = acc_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    fet_cnt_d   = fet_cnt_q;
    wd_d        = wd_q;
    out_data_d  = out_data_q;

    if (core_ack || (state_d != state_q)) wd_d = '0;
    else if (strobe)                      wd_d = wd_q + 1'b1;

    // A retiring word and a new word in the same cycle leave the hold full.
    if (load_ack) begin
      hold_full_d = 1'b0;
      ld_cnt_d    = ld_cnt_q + 1'b1;
    end
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
      acc_cnt_d   = acc_cnt_q + 1'b1;
    end
    if (last_load) begin
      ld_cnt_d  = '0;
      acc_cnt_d = '0;
    end

    if (fetch_ack) out_data_d = core_odata;
    if (out_hs)    fet_cnt_d  = last_out ? '0 : fet_cnt_q + 1'b1;

    if (abort || ((state_q == S_IDLE) && start)) begin
      hold_d      = '0;
      hold_full_d = 1'b0;
      acc_cnt_d   = '0;
      ld_cnt_d    = '0;
      fet_cnt_d   = '0;
      wd_d        = '0;
    end
    if (abort) out_data_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      acc_cnt_q   <= '0;
      ld_cnt_q    <= '0;
      fet_cnt_q   <= '0;
      wd_q        <= '0;
      out_data_q  <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      acc_cnt_q   <= acc_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      fet_cnt_q   <= fet_cnt_d;
      wd_q        <= wd_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef SKEIN_SEQ_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Counts every busy cycle, so it stops by itself once done returns the FSM to IDLE.
  always_comb begin
    cyc_d = cyc_q;
    if (abort || ((state_q == S_IDLE) && start)) cyc_d = '0;
    else if (busy && (cyc_q != 32'hFFFF_FFFF))   cyc_d = cyc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_skein_host_seq.sv
// tb_skein_host_seq: scoreboard bench for skein_host_seq with a behavioural skein_top core model.
// Stimulus and core model drive #1 after posedge; monitor samples on negedge.
`timescale 1ns/1ps
module tb_skein_host_seq;

  localparam int W   = 16;
  localparam int MSG = 32;
  localparam int DIG = 16;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [W-1:0] in_data;
  logic         in_valid, in_ready;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready;
  logic         busy, done, err;
  logic         core_init, core_load, core_fetch;
  logic [W-1:0] core_idata;
  logic         core_ack;
  logic [W-1:0] core_odata;
`ifdef SKEIN_SEQ_CYCLE_COUNT_EN
  logic [31:0]  cycles;
`endif

  skein_host_seq #(.W(W), .MSG_WORDS(MSG), .DIG_WORDS(DIG), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .core_init(core_init), .core_load(core_load), .core_fetch(core_fetch),
    .core_idata(core_idata), .core_ack(core_ack), .core_odata(core_odata)
`ifdef SKEIN_SEQ_CYCLE_COUNT_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0;

  // Test configuration and model bookkeeping.
  int         ack_delay = 1, stall_idx = -1, out_stall = 0;
  logic [W-1:0] ld_base = '0;
  bit         stop_feed = 1'b0, feed_busy = 1'b0;
  int         ld_seen = 0, f_seen = 0, init_cnt = 0, load_cyc = 0, load_run = 0, done_cnt = 0;
  int         model_age = 0, ready_wait = 0;
  bit         prev_ov = 1'b0, prev_ld_wait = 1'b0;
  logic [W-1:0] prev_out = '0, prev_idata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: acks a strobe after ack_delay cycles, never acks load word stall_idx.
  initial begin
    core_ack   = 1'b0;
    core_odata = '0;
    forever begin
      @(posedge clk);
      #1;
      core_odata = 16'hA000 + W'(f_seen);
      if (rst) begin
        core_ack  = 1'b0;
        model_age = 0;
      end else if (core_load || core_fetch) begin
        if (model_age >= ack_delay && !(core_load && ld_seen == stall_idx)) begin
          core_ack  = 1'b1;
          model_age = 0;
        end else begin
          core_ack  = 1'b0;
          model_age++;
        end
      end else begin
        core_ack  = 1'b0;
        model_age = 0;
      end
    end
  end

  // Consumer: holds out_ready low out_stall cycles per presented word.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && !rst) begin
        if (ready_wait >= out_stall) begin
          out_ready  = 1'b1;
          ready_wait = 0;
        end else begin
          out_ready = 1'b0;
          ready_wait++;
        end
      end else begin
        out_ready  = 1'b0;
        ready_wait = 0;
      end
    end
  end

  // Monitor: scoreboard pops on every output handshake, plus handshake protocol checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov      = 1'b0;
        prev_ld_wait = 1'b0;
      end else begin
        if (core_init) begin
          init_cnt++;
          ld_seen = 0;
          f_seen  = 0;
        end
        if (core_load) load_cyc++;
        if (core_load && prev_ld_wait) check("idata_stable", core_idata, prev_idata);
        if (core_load && core_ack) begin
          check("core_idata", core_idata, 32'(W'(ld_base + W'(ld_seen))));
          ld_seen++;
          load_run = 0;
        end else if (core_load) begin
          load_run++;
        end
        prev_ld_wait = core_load && !core_ack;
        prev_idata   = core_idata;
        if (core_fetch && core_ack) f_seen++;
        if (out_valid) begin
          check("fetch_in_out", core_fetch, 0);
          if (prev_ov) check("out_stable", out_data, prev_out);
        end
        prev_ov  = out_valid && !out_ready;
        prev_out = out_data;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("out_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, 32'(e.data));
            check("done_flag", done, 32'(e.last));
          end
        end else if (done) begin
          fail_now("done_spurious");
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic feeder(input logic [W-1:0] base);
    feed_busy = 1'b1;
    for (int i = 0; i < MSG; i++) begin
      if (stop_feed) break;
      in_data  = base + W'(i);
      in_valid = 1'b1;
      do @(negedge clk); while (!(in_ready || stop_feed));
      tick();
    end
    in_valid  = 1'b0;
    in_data   = '0;
    feed_busy = 1'b0;
  endtask

  task automatic wait_feeder();
    for (int c = 0; c < 200 && feed_busy; c++) @(negedge clk);
    if (feed_busy) fail_now("feeder_stuck");
  endtask

  task automatic begin_hash(input logic [W-1:0] base, input int delay, input int ostall,
                            input int stall);
    ack_delay = delay;
    out_stall = ostall;
    stall_idx = stall;
    ld_base   = base;
    init_cnt  = 0;
    load_cyc  = 0;
    done_cnt  = 0;
    stop_feed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    fork
      feeder(base);
    join_none
  endtask

  task automatic push_digest();
    for (int n = 0; n < DIG; n++) exp_q.push_back({16'hA000 + W'(n), n == DIG - 1});
  endtask

  task automatic run_hash(input string tag, input logic [W-1:0] base, input int delay,
                          input int ostall, input int exp_load_cyc);
    push_digest();
    begin_hash(base, delay, ostall, -1);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
    if (done_cnt == 0) fail_now({tag, "_done_timeout"});
    tick();
    tick();
    check({tag, "_init_pulses"}, init_cnt, 1);
    check({tag, "_load_acks"}, ld_seen, MSG);
    check({tag, "_load_cycles"}, load_cyc, exp_load_cyc);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
    wait_feeder();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_data = '0; in_valid = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_strobes", {core_init, core_load, core_fetch}, 0);
    check("rst_err_done", {err, done}, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: nominal, ack one cycle after each strobe -> two load cycles per word.
    run_hash("nominal", 16'h0000, 1, 0, 64);
`ifdef SKEIN_SEQ_CYCLE_COUNT_EN
    check("nominal_cycles", cycles, 114);
`endif

    // 2: back-to-back, ack every cycle -> core_load high for exactly 32 cycles.
    run_hash("b2b", 16'h1000, 0, 0, 32);

    // 3: output backpressure, out_ready low 5 cycles per word.
    run_hash("bp", 16'h2000, 1, 5, 64);

    // 4: word 3 never acked -> ERR after 16 load cycles.
    begin_hash(16'h0100, 1, 0, 3);
    for (int c = 0; c < 500 && !err; c++) @(negedge clk);
    if (!err) fail_now("to_err_timeout");
    check("to_wd_cycles", load_run, TMO);
    check("to_words_acked", ld_seen, 3);
    check("to_strobes", {core_init, core_load, core_fetch}, 0);
    check("to_in_ready", in_ready, 0);
    check("to_out_valid", out_valid, 0);
    check("to_busy", busy, 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("to_start_ignored_err", err, 1);
    check("to_start_ignored_busy", busy, 1);
    check("to_start_no_init", init_cnt, 1);
    stop_feed = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("to_abort_err", err, 0);
    check("to_abort_busy", busy, 0);
    wait_feeder();

    // 5: abort during fetch of digest word 7, then a clean full hash.
    push_digest();
    begin_hash(16'h0200, 1, 0, -1);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 3000 && !hit; c++) begin
        @(negedge clk);
        hit = core_fetch && (f_seen == 7);
      end
      if (!hit) fail_now("ab_reach_word7");
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_strobes", {core_init, core_load, core_fetch}, 0);
    check("ab_out_valid", out_valid, 0);
    check("ab_busy", busy, 0);
    check("ab_words_out", exp_q.size(), DIG - 7);
    exp_q.delete();
    wait_feeder();
    run_hash("post_abort", 16'h0300, 1, 2, 64);

    // 6: asynchronous reset in the middle of LOAD.
    begin_hash(16'h0400, 1, 0, -1);
    for (int c = 0; c < 500 && ld_seen < 10; c++) @(negedge clk);
    @(posedge clk);
    #3;
    stop_feed = 1'b1;
    rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_strobes", {core_init, core_load, core_fetch}, 0);
    check("ar_idata", core_idata, 0);
    check("ar_out", {out_valid, done, err}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("ar_idle_busy", busy, 0);
    check("ar_idle_load", core_load, 0);
    wait_feeder();
    run_hash("post_rst", 16'h0500, 0, 1, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
